// File: rtl/mccpu_mem_pkg.sv
// Shared constants for the multi-cycle CPU memory responder: the MMIO
// window nibble, register offsets inside the window, and the STATUS word layout.
package mccpu_mem_pkg;

  localparam logic [3:0] MMIO_NIBBLE = 4'hF;

  localparam logic [1:0] OFF_TX     = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CLR    = 2'd2;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 4;

  // Assemble the STATUS read word; bit 3 and bits 31:8 stay zero.
  function automatic logic [31:0] pack_status(input logic [3:0] count,
                                              input logic       ovf,
                                              input logic       full,
                                              input logic       empty);
    logic [31:0] s;
    s                    = 32'd0;
    s[ST_EMPTY]          = empty;
    s[ST_FULL]           = full;
    s[ST_OVF]            = ovf;
    s[ST_COUNT_LSB +: 4] = count;
    return s;
  endfunction

endpackage

// File: rtl/mccpu_io_fifo.sv
// Small TX FIFO between the CPU's MMIO store path and the external sink.
// A push is accepted when not full, or when a pop frees a slot in the same
// cycle. The head word reads zero while empty so the sink sees a clean bus
// after reset.
module mccpu_io_fifo #(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   din,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [31:0]   head
);

  logic [31:0]   slots [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_pop;
  logic          do_push;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == CW'(0));
  assign count   = cnt;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? 32'd0 : slots[rd_ptr];

  // Pointer and occupancy bookkeeping; reset drops every queued word.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      cnt    <= CW'(0);
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clock) begin
    if (do_push) slots[wr_ptr] <= din;
  end

endmodule

// File: rtl/mccpu_mem_responder.sv
// Memory-side responder for the multi-cycle CPU: word RAM plus an MMIO
// window at 0xF000_0000 whose TX register feeds a valid/ready FIFO.
// Optional feature macro: MEM_RESP_STATUS_EN enables the STATUS and CLR
// registers; without it those offsets read zero and overflow clears only
// on reset.
module mccpu_mem_responder
  import mccpu_mem_pkg::*;
#(
  parameter int    ADDR_W     = 8,
  parameter int    FIFO_DEPTH = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] madr,
  input  logic [31:0] tomem,
  input  logic        wmem,
  output logic [31:0] frommem,
  output logic [31:0] io_data,
  output logic        io_valid,
  input  logic        io_ready,
  output logic        io_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       mem [2**ADDR_W];
  logic              is_mmio;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  logic              ram_we;
  logic              tx_push;
  logic              clr_wr;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [31:0]       rd_data;
  logic              unused_bits;

  assign is_mmio = (madr[31:28] == MMIO_NIBBLE);
  assign idx     = madr[ADDR_W+1:2];
  assign off     = madr[3:2];
  assign ram_we  = wmem & ~is_mmio;
  assign tx_push = wmem & is_mmio & (off == OFF_TX);
  assign pop     = io_valid & io_ready;

`ifdef MEM_RESP_STATUS_EN
  assign clr_wr      = wmem & is_mmio & (off == OFF_CLR);
  assign unused_bits = ^{madr[27:ADDR_W+2], madr[1:0]};
`else
  assign clr_wr      = 1'b0;
  assign unused_bits = ^{madr[27:ADDR_W+2], madr[1:0], fifo_count};
`endif

  mccpu_io_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (resetn),
    .push  (tx_push),
    .pop   (pop),
    .din   (tomem),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (io_data)
  );

  assign io_valid = ~fifo_empty;

  // Read mux: RAM word or MMIO register, sampled pre-edge so stores read old data.
  always_comb begin
    rd_data = 32'd0;
    if (is_mmio) begin
      case (off)
`ifdef MEM_RESP_STATUS_EN
        OFF_STATUS: rd_data = pack_status(4'(fifo_count), io_overflow,
                                          fifo_full, fifo_empty);
`endif
        default:    rd_data = 32'd0;
      endcase
    end else begin
      rd_data = mem[idx];
    end
  end

  // One-cycle read data register, updated every clock including store cycles.
  always_ff @(posedge clock) begin
    if (resetn) frommem <= 32'd0;
    else        frommem <= rd_data;
  end

  // Sticky overflow: a dropped push sets it and beats a same-cycle clear.
  always_ff @(posedge clock) begin
    if (resetn)                              io_overflow <= 1'b0;
    else if (tx_push & fifo_full & ~pop)     io_overflow <= 1'b1;
    else if (clr_wr)                         io_overflow <= 1'b0;
    else                                     io_overflow <= io_overflow;
  end

  // Whole-word RAM store; reset leaves contents intact.
  always_ff @(posedge clock) begin
    if (ram_we) mem[idx] <= tomem;
  end

endmodule

// File: tb/tb_mccpu_mem_responder.sv
// Directed self-checking bench for mccpu_mem_responder (default parameters).
module tb_mccpu_mem_responder;

  logic        clock;
  logic        resetn;
  logic [31:0] madr;
  logic [31:0] tomem;
  logic        wmem;
  logic [31:0] frommem;
  logic [31:0] io_data;
  logic        io_valid;
  logic        io_ready;
  logic        io_overflow;

  int errors = 0;
  int checks = 0;

`ifdef MEM_RESP_STATUS_EN
  localparam logic        STATUS_EN = 1'b1;
`else
  localparam logic        STATUS_EN = 1'b0;
`endif

  logic        exp_ovf_after_clr;
  logic [31:0] exp_st_full_ovf;
  logic [31:0] exp_st_empty;
  logic [31:0] exp_st_full;

  mccpu_mem_responder dut (
    .clock       (clock),
    .resetn      (resetn),
    .madr        (madr),
    .tomem       (tomem),
    .wmem        (wmem),
    .frommem     (frommem),
    .io_data     (io_data),
    .io_valid    (io_valid),
    .io_ready    (io_ready),
    .io_overflow (io_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic r);
    madr     = a;
    tomem    = d;
    wmem     = w;
    io_ready = r;
    @(posedge clock);
    #1;
  endtask

  initial begin
    exp_ovf_after_clr = STATUS_EN ? 1'b0 : 1'b1;
    exp_st_full_ovf   = STATUS_EN ? 32'h0000_0046 : 32'h0000_0000;
    exp_st_empty      = STATUS_EN ? 32'h0000_0001 : 32'h0000_0000;
    exp_st_full       = STATUS_EN ? 32'h0000_0042 : 32'h0000_0000;

    resetn = 1'b1; madr = 32'd0; tomem = 32'd0; wmem = 1'b0; io_ready = 1'b0;
    step(32'd0, 32'd0, 1'b0, 1'b0);
    step(32'd0, 32'd0, 1'b0, 1'b0);
    check("rst_frommem", frommem, 32'd0);
    check("rst_valid",   {31'd0, io_valid}, 32'd0);
    check("rst_ovf",     {31'd0, io_overflow}, 32'd0);
    check("rst_iodata",  io_data, 32'd0);
    resetn = 1'b0;

    // Word 0 holds the boot instruction; read it back after one clock.
    step(32'h0000_0000, 32'h3C08_F000, 1'b1, 1'b0);
    step(32'h0000_0000, 32'd0, 1'b0, 1'b0);
    check("word0_read", frommem, 32'h3C08_F000);

    // Read-before-write on a store, then plain and aliased reads.
    step(32'h0000_0010, 32'h1111_1111, 1'b1, 1'b0);
    step(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("store_old_word", frommem, 32'h1111_1111);
    step(32'h0000_0010, 32'd0, 1'b0, 1'b0);
    check("read_0x10", frommem, 32'hDEAD_BEEF);
    step(32'h0000_0012, 32'd0, 1'b0, 1'b0);
    check("read_0x12_alias", frommem, 32'hDEAD_BEEF);
    step(32'hE000_0010, 32'd0, 1'b0, 1'b0);
    check("read_upper_alias", frommem, 32'hDEAD_BEEF);
    step(32'h0000_0400, 32'd0, 1'b0, 1'b0);
    check("read_idx_wrap", frommem, 32'h3C08_F000);

    // Five TX stores into a four-deep FIFO with the sink stalled.
    step(32'hF000_0000, 32'd1, 1'b1, 1'b0);
    check("tx_read_zero", frommem, 32'd0);
    check("valid_after_push", {31'd0, io_valid}, 32'd1);
    step(32'hF000_0000, 32'd2, 1'b1, 1'b0);
    step(32'hF000_0000, 32'd3, 1'b1, 1'b0);
    step(32'hF000_0000, 32'd4, 1'b1, 1'b0);
    check("ovf_before_5th", {31'd0, io_overflow}, 32'd0);
    step(32'hF000_0000, 32'd5, 1'b1, 1'b0);
    check("ovf_after_5th", {31'd0, io_overflow}, 32'd1);
    check("head_after_fill", io_data, 32'd1);
    step(32'h0000_0000, 32'd0, 1'b0, 1'b0);
    check("head_stable_stall", io_data, 32'd1);
    step(32'hF000_0004, 32'd0, 1'b0, 1'b0);
    check("status_full_ovf", frommem, exp_st_full_ovf);

    for (int k = 1; k <= 4; k++) begin
      check("drain_order", io_data, 32'(k));
      step(32'h0000_0000, 32'd0, 1'b0, 1'b1);
    end
    check("drained_valid", {31'd0, io_valid}, 32'd0);

    // CLR write, then STATUS and reserved offset.
    step(32'hF000_0008, 32'd0, 1'b1, 1'b0);
    check("ovf_after_clr", {31'd0, io_overflow}, {31'd0, exp_ovf_after_clr});
    step(32'hF000_0004, 32'd0, 1'b0, 1'b0);
    check("status_empty", frommem, exp_st_empty);
    step(32'hF000_000C, 32'h99, 1'b1, 1'b0);
    step(32'hF000_000C, 32'd0, 1'b0, 1'b0);
    check("reserved_read", frommem, 32'd0);
    check("reserved_no_push", {31'd0, io_valid}, 32'd0);

    // Full FIFO: push and pop in the same cycle is accepted.
    step(32'hF000_0000, 32'h10, 1'b1, 1'b0);
    step(32'hF000_0000, 32'h20, 1'b1, 1'b0);
    step(32'hF000_0000, 32'h30, 1'b1, 1'b0);
    step(32'hF000_0000, 32'h40, 1'b1, 1'b0);
    step(32'hF000_0004, 32'd0, 1'b0, 1'b0);
    check("status_full", frommem, exp_st_full);
    step(32'hF000_0000, 32'h55, 1'b1, 1'b1);
    check("pushpop_no_ovf", {31'd0, io_overflow}, {31'd0, exp_ovf_after_clr});
    check("pushpop_head", io_data, 32'h20);
    step(32'hF000_0004, 32'd0, 1'b0, 1'b0);
    check("pushpop_count", frommem, exp_st_full);
    check("drain2_0", io_data, 32'h20);
    step(32'h0000_0000, 32'd0, 1'b0, 1'b1);
    check("drain2_1", io_data, 32'h30);
    step(32'h0000_0000, 32'd0, 1'b0, 1'b1);
    check("drain2_2", io_data, 32'h40);
    step(32'h0000_0000, 32'd0, 1'b0, 1'b1);
    check("drain2_3", io_data, 32'h55);
    step(32'h0000_0000, 32'd0, 1'b0, 1'b1);
    check("drain2_empty", {31'd0, io_valid}, 32'd0);

    // Reset with three words queued and a pending handshake.
    step(32'hF000_0000, 32'hA, 1'b1, 1'b0);
    step(32'hF000_0000, 32'hB, 1'b1, 1'b0);
    step(32'hF000_0000, 32'hC, 1'b1, 1'b0);
    check("queued_valid", {31'd0, io_valid}, 32'd1);
    resetn = 1'b1;
    step(32'h0000_0010, 32'd0, 1'b0, 1'b0);
    resetn = 1'b0;
    check("midrst_valid",   {31'd0, io_valid}, 32'd0);
    check("midrst_frommem", frommem, 32'd0);
    check("midrst_iodata",  io_data, 32'd0);
    check("midrst_ovf",     {31'd0, io_overflow}, 32'd0);
    step(32'h0000_0010, 32'd0, 1'b0, 1'b1);
    check("ram_kept", frommem, 32'hDEAD_BEEF);
    check("still_empty", {31'd0, io_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
